// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM stage.
package mem_pkg;
  typedef enum logic [3:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, UR, UW_PULSE, UW_TBRE, UW_TSRE, DONE
  } state_t;
  localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;
  localparam int STAT_READY_BIT = 1;
  localparam int STAT_TXEMPTY_BIT = 0;
  localparam int SEL_SRAM = 2;
  localparam int SEL_UDATA = 1;
  localparam int SEL_USTAT = 0;
endpackage

// File: rtl/mem_addr_decode.sv
// mem_addr_decode: classifies a MEM-stage access as SRAM, UART data or UART status.
module mem_addr_decode
  import mem_pkg::*;
#(
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
  input  logic [15:0] alu_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  output logic [2:0]  sel,
  output logic        req,
  output logic        is_write
);
  logic udata, ustat;
  assign udata = alu_in == UART_DATA_ADDR;
  assign ustat = alu_in == UART_STAT_ADDR;
  assign sel = {!udata && !ustat, udata, ustat};
  assign req = memread_in | memwrite_in;
  assign is_write = memwrite_in;
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage sequencing multi-cycle SRAM/UART accesses on the shared bus.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES    = 1,
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        controlwb_in,
  input  logic [15:0] alu_in,
  input  logic [15:0] wdata_in,
  input  logic [3:0]  wreg_in,
  output logic        stall,
  output logic        controlwb_out,
  output logic [3:0]  wreg_out,
  output logic [15:0] wb_data_out,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_data_o,
  input  logic [15:0] ram_data_i,
  output logic        ram_data_oe,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);
  state_t state, state_nx;
  logic [2:0] cnt;
  logic [15:0] rdata_q, status;
  logic [2:0] sel;
  logic req, is_write, last, strobe_rd, drive;
  mem_addr_decode #(.UART_DATA_ADDR(UART_DATA_ADDR), .UART_STAT_ADDR(UART_STAT_ADDR)) u_dec (
    .alu_in(alu_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .sel(sel), .req(req), .is_write(is_write)
  );
  assign strobe_rd = state == RD || state == UR;
  assign last = cnt == 3'(WAIT_CYCLES - 1);
  always_comb begin
    status = '0;
    status[STAT_READY_BIT] = uart_data_ready;
    status[STAT_TXEMPTY_BIT] = uart_tbre & uart_tsre;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt <= (strobe_rd && !last) ? cnt + 3'd1 : 3'd0;
      if (state == IDLE && req && !is_write && sel[SEL_USTAT]) rdata_q <= status;
      else if (strobe_rd && last) rdata_q <= ram_data_i;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (req) state_nx = sel[SEL_USTAT] ? DONE :
                                    sel[SEL_UDATA] ? (is_write ? UW_PULSE : UR) :
                                                     (is_write ? WR_SETUP : RD);
      RD, UR:   if (last) state_nx = DONE;
      WR_SETUP: state_nx = WR_PULSE;
      WR_PULSE: state_nx = WR_HOLD;
      WR_HOLD:  state_nx = DONE;
      UW_PULSE: state_nx = UW_TBRE;
      UW_TBRE:  if (uart_tbre) state_nx = UW_TSRE;
      UW_TSRE:  if (uart_tsre) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end
  // Bus strobes depend on the state register alone so they never glitch on input changes.
  always_comb begin
    drive = state inside {WR_SETUP, WR_PULSE, WR_HOLD, UW_PULSE};
    ram_data_oe = drive;
    ram_data_o = drive ? wdata_in : '0;
    ram_en_n = !(state inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
    ram_oe_n = state != RD;
    ram_we_n = state != WR_PULSE;
    uart_rdn = state != UR;
    uart_wrn = state != UW_PULSE;
    stall = rst && ((state == IDLE && req) || !(state inside {IDLE, DONE}));
  end
  assign ram_addr = {2'b00, alu_in};
  assign controlwb_out = controlwb_in;
  assign wreg_out = wreg_in;
  assign wb_data_out = memread_in ? rdata_q : alu_in;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed checks of the MEM stage against hand-computed results.
module tb_mem_access;
  logic clk = 0, rst = 0;
  logic memread_in = 0, memwrite_in = 0, controlwb_in = 0;
  logic [15:0] alu_in = 0, wdata_in = 0;
  logic [3:0] wreg_in = 0;
  logic stall, controlwb_out, ram_data_oe, ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic [3:0] wreg_out;
  logic [15:0] wb_data_out, ram_data_o, ram_data_i;
  logic [17:0] ram_addr;
  logic uart_data_ready = 0, uart_tbre = 0, uart_tsre = 0;
  logic [15:0] mem [256];
  int n_cmp = 0, n_err = 0;
  int stalls, we_lo, oe_lo, rdn_lo, wrn_lo, en_lo, since;
  logic [17:0] addr_seen;
  logic [15:0] dout_seen, wb;

  mem_access dut (
    .clk(clk), .rst(rst), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .controlwb_in(controlwb_in), .alu_in(alu_in), .wdata_in(wdata_in), .wreg_in(wreg_in),
    .stall(stall), .controlwb_out(controlwb_out), .wreg_out(wreg_out), .wb_data_out(wb_data_out),
    .ram_addr(ram_addr), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .ram_data_oe(ram_data_oe),
    .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .uart_rdn(uart_rdn),
    .uart_wrn(uart_wrn), .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #5 clk = ~clk;

  // Simple SRAM and UART receive-register model on the shared bus.
  assign ram_data_i = (!ram_en_n && !ram_oe_n) ? mem[ram_addr[7:0]] : !uart_rdn ? 16'h005A : 16'h0000;
  always @(posedge clk) if (!ram_en_n && !ram_we_n) mem[ram_addr[7:0]] <= ram_data_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data, input bit uart_auto);
    memread_in = rd; memwrite_in = wr; alu_in = addr; wdata_in = data;
    stalls = 0; we_lo = 0; oe_lo = 0; rdn_lo = 0; wrn_lo = 0; en_lo = 0; since = -1;
    addr_seen = '0; dout_seen = '0;
    if (uart_auto) begin uart_tbre = 0; uart_tsre = 0; end
    #1;
    for (int i = 0; i < 50 && stall; i++) begin
      stalls++;
      we_lo += int'(!ram_we_n); oe_lo += int'(!ram_oe_n); rdn_lo += int'(!uart_rdn);
      wrn_lo += int'(!uart_wrn); en_lo += int'(!ram_en_n);
      if (!ram_en_n) addr_seen = ram_addr;
      if (ram_data_oe) dout_seen = ram_data_o;
      if (uart_auto) begin
        since = !uart_wrn ? 0 : (since >= 0 ? since + 1 : since);
        uart_tbre = since >= 3;
        uart_tsre = since >= 5;
      end
      step();
    end
    chk("access_done", {31'd0, stall}, 32'd0);
    wb = wb_data_out;
    memread_in = 0; memwrite_in = 0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    step(); step();
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_en_n", {31'd0, ram_en_n}, 1);
    chk("rst_we_n", {31'd0, ram_we_n}, 1);
    chk("rst_data_oe", {31'd0, ram_data_oe}, 0);
    chk("rst_data_o", {16'd0, ram_data_o}, 0);
    rst = 1;
    step();
    alu_in = 16'h1234; controlwb_in = 1; wreg_in = 4'd3;
    #1;
    chk("pass_stall", {31'd0, stall}, 0);
    chk("pass_wb", {16'd0, wb_data_out}, 32'h1234);
    chk("pass_cwb", {31'd0, controlwb_out}, 1);
    chk("pass_wreg", {28'd0, wreg_out}, 3);
    step();
    access(0, 1, 16'h0040, 16'hBEEF, 0);
    chk("sw_stalls", stalls, 4);
    chk("sw_we_lo", we_lo, 1);
    chk("sw_addr", {14'd0, addr_seen}, 32'h00040);
    chk("sw_dout", {16'd0, dout_seen}, 32'hBEEF);
    access(1, 0, 16'h0040, 16'h0000, 0);
    chk("sr_stalls", stalls, 2);
    chk("sr_oe_lo", oe_lo, 1);
    chk("sr_wb", {16'd0, wb}, 32'hBEEF);
    uart_data_ready = 1; uart_tbre = 1; uart_tsre = 0;
    access(1, 0, 16'hBF01, 16'h0000, 0);
    chk("st_stalls", stalls, 1);
    chk("st_wb", {16'd0, wb}, 32'h0002);
    access(0, 1, 16'hBF00, 16'h0041, 1);
    chk("uw_stalls", stalls, 7);
    chk("uw_wrn_lo", wrn_lo, 1);
    chk("uw_en_lo", en_lo, 0);
    chk("uw_dout", {16'd0, dout_seen}, 32'h0041);
    access(1, 0, 16'hBF00, 16'h0000, 0);
    chk("ur_stalls", stalls, 2);
    chk("ur_rdn_lo", rdn_lo, 1);
    chk("ur_wb", {16'd0, wb}, 32'h005A);
    access(1, 1, 16'h0010, 16'h1111, 0);
    chk("rw_stalls", stalls, 4);
    chk("rw_we_lo", we_lo, 1);
    chk("rw_oe_lo", oe_lo, 0);
    access(1, 0, 16'h0010, 16'h0000, 0);
    chk("rw_readback", {16'd0, wb}, 32'h1111);
    memwrite_in = 1; alu_in = 16'h0020; wdata_in = 16'h7777;
    step(); step();
    chk("ab_pulse", {31'd0, ram_we_n}, 0);
    rst = 0; memwrite_in = 0;
    step();
    chk("ab_we_n", {31'd0, ram_we_n}, 1);
    chk("ab_data_oe", {31'd0, ram_data_oe}, 0);
    chk("ab_stall", {31'd0, stall}, 0);
    chk("ab_en_n", {31'd0, ram_en_n}, 1);
    memread_in = 1; alu_in = 16'h0030;
    #1;
    chk("ab_rdata", {16'd0, wb_data_out}, 0);
    memread_in = 0; rst = 1;
    step();
    chk("ab_idle_stall", {31'd0, stall}, 0);
    chk("ab_idle_wrn", {31'd0, uart_wrn}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 16-bit pipeline, directly downstream of the EXE/MEM register.
- Consumes memread/memwrite, the ALU result (used as the address), the store data, the writeback control bit and the destination register.
- Runs multi-cycle accesses to the shared RAM1 data bus: SRAM, or the UART at 0xBF00/0xBF01.
- Holds the whole pipeline via stall until the access finishes, and presents the writeback value to MEM/WB.

Parameters:
- WAIT_CYCLES, 1, cycles the read strobe (SRAM oe_n or UART rdn) is held low before data capture; legal range 1..7.
- UART_DATA_ADDR, 16'hBF00, UART data register address.
- UART_STAT_ADDR, 16'hBF01, UART status register address (read-only).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset.
- memread_in  in  1  load request.
- memwrite_in  in  1  store request.
- controlwb_in  in  1  register-writeback enable from EXE/MEM.
- alu_in  in  16  ALU result; the address for loads and stores.
- wdata_in  in  16  store data.
- wreg_in  in  4  destination register.
- stall  out  1  freeze all upstream pipeline registers.
- controlwb_out  out  1  writeback enable to MEM/WB.
- wreg_out  out  4  destination register to MEM/WB.
- wb_data_out  out  16  writeback value.
- ram_addr  out  18  SRAM address.
- ram_data_o  out  16  bus drive value.
- ram_data_i  in  16  bus sampled value.
- ram_data_oe  out  1  drive enable for the shared bus tri-state.
- ram_en_n  out  1  SRAM chip enable, active low.
- ram_oe_n  out  1  SRAM output enable, active low.
- ram_we_n  out  1  SRAM write enable, active low.
- uart_rdn  out  1  UART read strobe, active low.
- uart_wrn  out  1  UART write strobe, active low.
- uart_data_ready  in  1  UART receive data available.
- uart_tbre  in  1  UART transmit buffer empty.
- uart_tsre  in  1  UART transmit shift register empty.

Behaviour:
- Inputs are stable at posedge: EXE/MEM updates on negedge and is frozen while stall=1.
- Pass-through:
  - controlwb_out = controlwb_in and wreg_out = wreg_in, combinationally.
  - wb_data_out = memread_in ? rdata_q : alu_in.
  - rdata_q is a 16-bit register; its reset value is 0.
- Request = memread_in | memwrite_in. If both are set, the access is a write and the read is ignored.
- Address decode:
  - alu_in == UART_DATA_ADDR selects UART data.
  - alu_in == UART_STAT_ADDR selects UART status.
  - Any other address selects SRAM, with ram_addr = {2'b00, alu_in}.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, UR, UW_PULSE, UW_TBRE, UW_TSRE, DONE.
- stall:
  - Combinational: 1 when (state == IDLE and request) or state is neither IDLE nor DONE.
  - 0 when rst = 0.
- IDLE transitions on a request:
  - SRAM read -> RD.
  - SRAM write -> WR_SETUP.
  - UART data read -> UR.
  - UART data write -> UW_PULSE.
  - Status read: rdata_q <= {14'b0, uart_data_ready, uart_tbre & uart_tsre}, -> DONE.
  - Status write: discarded, -> DONE.
- RD:
  - Drives ram_en_n=0, ram_oe_n=0, ram_data_oe=0.
  - A counter runs for WAIT_CYCLES cycles.
  - On the last cycle: rdata_q <= ram_data_i, -> DONE.
- WR_SETUP: address and data driven, ram_data_oe=1, ram_en_n=0, ram_we_n=1.
- WR_PULSE: ram_we_n=0.
- WR_HOLD: ram_we_n=1 with data still driven, then -> DONE.
- UR:
  - ram_en_n=1, uart_rdn=0 for WAIT_CYCLES cycles.
  - On the last cycle: rdata_q <= ram_data_i, -> DONE.
- UW_PULSE: ram_en_n=1, ram_data_oe=1, ram_data_o=wdata_in, uart_wrn=0 for one cycle.
- UW_TBRE: waits for uart_tbre=1.
- UW_TSRE: waits for uart_tsre=1, then -> DONE. No timeout.
- DONE:
  - stall=0 so MEM/WB latches wb_data_out at this negedge.
  - Unconditionally -> IDLE; the request is never re-issued from DONE.
- Stall cycle counts:
  - SRAM read: 1+WAIT_CYCLES.
  - SRAM write: 4.
  - Status access: 1.
  - UART read: 1+WAIT_CYCLES.
  - UART write: 3 plus the wait cycles.
- Strobe outputs are decoded from the state register only, so they are glitch-free.
- Idle strobe values: ram_en_n=1, ram_oe_n=1, ram_we_n=1, uart_rdn=1, uart_wrn=1, ram_data_oe=0, ram_data_o=0.
- Reset (rst=0 at posedge), including mid-access:
  - state <= IDLE, wait counter <= 0, rdata_q <= 0.
  - Strobes take their idle values from the next cycle.
  - The aborted access is dropped.

Decomposition:
- Package mem_pkg: state enum, UART_DATA_ADDR/UART_STAT_ADDR defaults, status bit positions.
- One natural sub-module, mem_addr_decode: combinational, alu_in plus read/write in, one-hot {sram, uart_data, uart_stat} plus is_write out.

Test Plan:
- No request, alu_in=16'h1234, controlwb_in=1, wreg_in=3 -> stall=0; wb_data_out=16'h1234; controlwb_out=1; wreg_out=3.
- SRAM write to 16'h0040 with data 16'hBEEF, then read of 16'h0040 (WAIT_CYCLES=1) -> write: stall 4 cycles, ram_we_n low exactly 1 cycle, ram_addr=18'h00040; read: stall 2 cycles, wb_data_out=16'hBEEF in DONE.
- Status read at 16'hBF01 with data_ready=1, tbre=1, tsre=0 -> 1 stall cycle; wb_data_out=16'h0002.
- UART write of 16'h0041 at 16'hBF00, tbre rises 3 cycles and tsre 5 cycles after the wrn pulse -> uart_wrn low exactly 1 cycle; ram_en_n=1 throughout; stall held until tsre=1; DONE follows.
- memread_in=1 and memwrite_in=1 at 16'h0010 -> behaves as SRAM write; ram_oe_n never asserted.
- rst=0 during WR_PULSE -> next cycle: ram_we_n=1, ram_data_oe=0, stall=0, state IDLE, rdata_q=0.
